// File: rtl/swcell_arb_pipe.sv
// Column switch cell: merges the current pixel and NUP upstream branches into one
// registered downstream word stream. Hit flags and the broadcast bus are registered too.
//
// Handshake: a source offers a word with its valid line. Its read line is high in a
// cycle where that word is taken. Read is combinational: grant & load, where
// load = !dnValid | dnRead. A source that sees read high moves to its next word, or
// drops valid, in the following cycle. The output register holds dnData while dnValid
// is high and dnRead is low.
module swcell_arb_pipe #(
    parameter int DATAWIDTH  = 46,
    parameter int HITSWIDTH  = 5,
    parameter int BCSTWIDTH  = 12,
    parameter int NUP        = 2,
    parameter int ARBMODE    = 0,
    parameter int BCSTSTAGES = 1,
    parameter int CNTWIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ctValid,
    input  logic [DATAWIDTH-1:0]     ctData,
    input  logic [HITSWIDTH-1:0]     ctHits,
    output logic                     ctRead,
    input  logic [NUP-1:0]           upValid,
    input  logic [NUP*DATAWIDTH-1:0] upData,
    input  logic [NUP*HITSWIDTH-1:0] upHits,
    output logic [NUP-1:0]           upRead,
    output logic                     dnValid,
    output logic [DATAWIDTH-1:0]     dnData,
    output logic [2:0]               dnSrc,
    input  logic                     dnRead,
    output logic [HITSWIDTH-1:0]     dnHits,
    input  logic [BCSTWIDTH-1:0]     dnBCST,
    output logic [BCSTWIDTH-1:0]     ctBCST,
    output logic [BCSTWIDTH-1:0]     upBCST,
    input  logic                     clrCount,
    output logic [CNTWIDTH-1:0]      wordCount
);

    localparam int NSRC = NUP + 1;

    logic                 load;
    logic                 doGrant;
    logic                 grantValid;
    logic [2:0]           grantIdx;
    logic [3:0]           candIdx;
    logic                 candReq;
    logic [2:0]           rrPtr;
    logic [2:0]           nextPtr;
    logic [DATAWIDTH-1:0] selData;
    logic [HITSWIDTH-1:0] hitsOr;
    logic [BCSTWIDTH-1:0] bcstPipe [BCSTSTAGES];

    assign load = !dnValid || dnRead;

    // Walk the requesters from the start index (0 in fixed mode, rrPtr in
    // round-robin mode), wrapping modulo NSRC; the first valid one wins.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = 3'd0;
        candIdx    = 4'd0;
        candReq    = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            candIdx = (ARBMODE == 1) ? ({1'b0, rrPtr} + 4'(k)) : 4'(k);
            if (candIdx >= 4'(NSRC)) begin
                candIdx = candIdx - 4'(NSRC);
            end
            candReq = ctValid;
            for (int i = 0; i < NUP; i++) begin
                if (candIdx == 4'(i + 1)) begin
                    candReq = upValid[i];
                end
            end
            if (!grantValid && candReq) begin
                grantValid = 1'b1;
                grantIdx   = candIdx[2:0];
            end
        end
    end

    // Reads are suppressed while reset is low, so no source counts as acked.
    assign doGrant = grantValid && load && reset;

    always_comb begin
        ctRead = doGrant && (grantIdx == 3'd0);
        upRead = '0;
        for (int i = 0; i < NUP; i++) begin
            upRead[i] = doGrant && (grantIdx == 3'(i + 1));
        end
    end

    always_comb begin
        selData = ctData;
        for (int i = 0; i < NUP; i++) begin
            if (grantIdx == 3'(i + 1)) begin
                selData = upData[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    always_comb begin
        hitsOr = ctHits;
        for (int i = 0; i < NUP; i++) begin
            hitsOr = hitsOr | upHits[i*HITSWIDTH +: HITSWIDTH];
        end
    end

    assign nextPtr = (grantIdx == 3'(NSRC - 1)) ? 3'd0 : grantIdx + 3'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dnValid <= 1'b0;
            dnData  <= '0;
            dnSrc   <= 3'd0;
        end else if (load) begin
            if (doGrant) begin
                dnValid <= 1'b1;
                dnData  <= selData;
                dnSrc   <= grantIdx;
            end else begin
                dnValid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rrPtr <= 3'd0;
        end else if (ARBMODE == 1 && doGrant) begin
            rrPtr <= nextPtr;
        end
    end

    // Clear beats a same-cycle grant; the count sticks at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wordCount <= '0;
        end else if (clrCount) begin
            wordCount <= '0;
        end else if (doGrant && wordCount != '1) begin
            wordCount <= wordCount + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dnHits <= '0;
        end else begin
            dnHits <= hitsOr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < BCSTSTAGES; s++) begin
                bcstPipe[s] <= '0;
            end
        end else begin
            bcstPipe[0] <= dnBCST;
            for (int s = 1; s < BCSTSTAGES; s++) begin
                bcstPipe[s] <= bcstPipe[s-1];
            end
        end
    end

    assign ctBCST = bcstPipe[BCSTSTAGES-1];
    assign upBCST = bcstPipe[BCSTSTAGES-1];

endmodule

// File: tb/tb_swcell_arb_pipe.sv
// Bench for swcell_arb_pipe: a fixed-priority instance (3 broadcast stages, 4-bit counter)
// and a round-robin instance share all inputs and are checked against a reference model.
module tb_swcell_arb_pipe;

    localparam int DW   = 46;
    localparam int HW   = 5;
    localparam int BW   = 12;
    localparam int NUP  = 2;
    localparam int NSRC = NUP + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              ctValid;
    logic [DW-1:0]     ctData;
    logic [HW-1:0]     ctHits;
    logic [NUP-1:0]    upValid;
    logic [NUP*DW-1:0] upData;
    logic [NUP*HW-1:0] upHits;
    logic              dnRead;
    logic [BW-1:0]     dnBCST;
    logic              clrCount;

    logic              ctRead0, ctRead1;
    logic [NUP-1:0]    upRead0, upRead1;
    logic              dnValid0, dnValid1;
    logic [DW-1:0]     dnData0, dnData1;
    logic [2:0]        dnSrc0, dnSrc1;
    logic [HW-1:0]     dnHits0, dnHits1;
    logic [BW-1:0]     ctBCST0, ctBCST1, upBCST0, upBCST1;
    logic [3:0]        wordCount0;
    logic [15:0]       wordCount1;

    swcell_arb_pipe #(.DATAWIDTH(DW), .HITSWIDTH(HW), .BCSTWIDTH(BW), .NUP(NUP),
                      .ARBMODE(0), .BCSTSTAGES(3), .CNTWIDTH(4)) dut0 (
        .clk(clk), .reset(reset), .ctValid(ctValid), .ctData(ctData), .ctHits(ctHits),
        .ctRead(ctRead0), .upValid(upValid), .upData(upData), .upHits(upHits),
        .upRead(upRead0), .dnValid(dnValid0), .dnData(dnData0), .dnSrc(dnSrc0),
        .dnRead(dnRead), .dnHits(dnHits0), .dnBCST(dnBCST), .ctBCST(ctBCST0),
        .upBCST(upBCST0), .clrCount(clrCount), .wordCount(wordCount0));

    swcell_arb_pipe #(.DATAWIDTH(DW), .HITSWIDTH(HW), .BCSTWIDTH(BW), .NUP(NUP),
                      .ARBMODE(1), .BCSTSTAGES(1), .CNTWIDTH(16)) dut1 (
        .clk(clk), .reset(reset), .ctValid(ctValid), .ctData(ctData), .ctHits(ctHits),
        .ctRead(ctRead1), .upValid(upValid), .upData(upData), .upHits(upHits),
        .upRead(upRead1), .dnValid(dnValid1), .dnData(dnData1), .dnSrc(dnSrc1),
        .dnRead(dnRead), .dnHits(dnHits1), .dnBCST(dnBCST), .ctBCST(ctBCST1),
        .upBCST(upBCST1), .clrCount(clrCount), .wordCount(wordCount1));

    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;

    // Reference model state
    logic          mValid0, mValid1;
    int            mCnt0, mCnt1, mPtr;
    logic [HW-1:0] mHits;
    logic [BW-1:0] bPipe [3];
    logic [48:0]   lastWord0, lastWord1;
    logic [48:0]   exp_q0[$];
    logic [48:0]   exp_q1[$];
    int            lastG0, lastG1;

    typedef struct {
        logic       ctV;
        logic [1:0] upV;
        logic       dnR;
        logic [2:0] expRd0;
    } tbVec;
    tbVec vecs[10];
    int   rrSeq[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input int mode, input int ptr, input logic [2:0] req);
        for (int k = 0; k < NSRC; k++) begin
            int idx;
            idx = (mode == 1) ? (ptr + k) % NSRC : k;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [48:0] srcWord(input int g);
        if (g == 0) return {3'd0, ctData};
        return {3'(g), upData[(g-1)*DW +: DW]};
    endfunction

    task automatic modelClear();
        mValid0 = 1'b0; mValid1 = 1'b0;
        mCnt0 = 0; mCnt1 = 0; mPtr = 0;
        mHits = '0;
        for (int s = 0; s < 3; s++) bPipe[s] = '0;
        lastWord0 = '0; lastWord1 = '0;
        exp_q0.delete(); exp_q1.delete();
    endtask

    task automatic setInputs(input logic cv, input logic [1:0] uv, input logic dr);
        ctValid = cv;
        upValid = uv;
        dnRead  = dr;
        ctData  = DW'({$urandom(), $urandom()});
        upData  = (NUP*DW)'({$urandom(), $urandom(), $urandom()});
    endtask

    // Called just after a rising edge with inputs driven; ends just after the next edge.
    task automatic step();
        logic [2:0]    req;
        logic [HW-1:0] nextHits;
        logic [48:0]   w;
        logic          load0, load1;
        int            g0, g1;
        #1;
        req   = {upValid, ctValid};
        load0 = !mValid0 || dnRead;
        load1 = !mValid1 || dnRead;
        g0 = load0 ? pick(0, 0, req) : -1;
        g1 = load1 ? pick(1, mPtr, req) : -1;
        check("read0", {upRead0, ctRead0}, (g0 >= 0) ? (3'b001 << g0) : 3'b000);
        check("read1", {upRead1, ctRead1}, (g1 >= 0) ? (3'b001 << g1) : 3'b000);
        if (g0 >= 0) exp_q0.push_back(srcWord(g0));
        if (g1 >= 0) exp_q1.push_back(srcWord(g1));
        nextHits = ctHits | upHits[HW-1:0] | upHits[2*HW-1:HW];
        @(posedge clk);
        #1;
        if (load0) mValid0 = (g0 >= 0);
        if (load1) mValid1 = (g1 >= 0);
        if (clrCount) mCnt0 = 0; else if (g0 >= 0 && mCnt0 < 15) mCnt0++;
        if (clrCount) mCnt1 = 0; else if (g1 >= 0 && mCnt1 < 65535) mCnt1++;
        if (g1 >= 0) mPtr = (g1 + 1) % NSRC;
        mHits = nextHits;
        bPipe[2] = bPipe[1]; bPipe[1] = bPipe[0]; bPipe[0] = dnBCST;
        if (g0 >= 0 && exp_q0.size() > 0) lastWord0 = exp_q0.pop_front();
        if (g1 >= 0 && exp_q1.size() > 0) lastWord1 = exp_q1.pop_front();
        w = lastWord0;
        check("dnValid0", dnValid0, mValid0);
        check("dnWord0", {dnSrc0, dnData0}, w);
        check("dnValid1", dnValid1, mValid1);
        check("dnWord1", {dnSrc1, dnData1}, lastWord1);
        check("wordCount0", wordCount0, mCnt0);
        check("wordCount1", wordCount1, mCnt1);
        check("dnHits0", dnHits0, mHits);
        check("dnHits1", dnHits1, mHits);
        check("ctBCST0", ctBCST0, bPipe[2]);
        check("upBCST0", upBCST0, bPipe[2]);
        check("ctBCST1", ctBCST1, bPipe[0]);
        check("upBCST1", upBCST1, bPipe[0]);
        lastG0 = g0;
        lastG1 = g1;
    endtask

    task automatic doReset();
        reset = 1'b0;
        ctValid = 1'b0; upValid = '0; dnRead = 1'b0; clrCount = 1'b0;
        ctData = '0; upData = '0; ctHits = '0; upHits = '0; dnBCST = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst dnValid", {dnValid1, dnValid0}, 2'b00);
        check("rst dnData", {dnData1, dnData0}, '0);
        check("rst dnSrc", {dnSrc1, dnSrc0}, 6'd0);
        check("rst dnHits", {dnHits1, dnHits0}, '0);
        check("rst bcst", {ctBCST0, upBCST0, ctBCST1, upBCST1}, '0);
        check("rst count", {wordCount1, wordCount0}, '0);
        reset = 1'b1;
        modelClear();
    endtask

    initial begin
        vecs[0] = '{1'b1, 2'b11, 1'b1, 3'b001};
        vecs[1] = '{1'b1, 2'b11, 1'b1, 3'b001};
        vecs[2] = '{1'b1, 2'b11, 1'b1, 3'b001};
        vecs[3] = '{1'b0, 2'b11, 1'b1, 3'b010};
        vecs[4] = '{1'b0, 2'b10, 1'b1, 3'b100};
        vecs[5] = '{1'b1, 2'b10, 1'b0, 3'b000};
        vecs[6] = '{1'b1, 2'b10, 1'b1, 3'b001};
        vecs[7] = '{1'b0, 2'b00, 1'b1, 3'b000};
        vecs[8] = '{1'b0, 2'b01, 1'b0, 3'b010};
        vecs[9] = '{1'b0, 2'b00, 1'b0, 3'b000};
        rrSeq = '{0, 1, 2, 0, 1, 2};

        doReset();

        // Single word from the current pixel
        setInputs(1'b1, 2'b00, 1'b1);
        ctData = DW'(46'h1234);
        #1;
        check("single ctRead", ctRead0, 1'b1);
        step();
        check("single dnData", dnData0, 46'h1234);
        check("single dnSrc", dnSrc0, 3'd0);
        check("single count", wordCount0, 4'd1);
        setInputs(1'b0, 2'b00, 1'b1);
        step();

        // Fixed priority table on a fresh reset
        doReset();
        for (int i = 0; i < 10; i++) begin
            setInputs(vecs[i].ctV, vecs[i].upV, vecs[i].dnR);
            #1;
            check($sformatf("vec%0d rd0", i), {upRead0, ctRead0}, vecs[i].expRd0);
            step();
        end

        // Round-robin rotation from pointer 0
        doReset();
        for (int i = 0; i < 6; i++) begin
            setInputs(1'b1, 2'b11, 1'b1);
            step();
            check($sformatf("rr src%0d", i), dnSrc1, 3'(rrSeq[i]));
        end

        // Backpressure: output full, downstream stalled
        for (int i = 0; i < 3; i++) begin
            setInputs(1'b1, 2'b00, 1'b0);
            #1;
            check("bp ctRead0", ctRead0, 1'b0);
            step();
        end
        setInputs(1'b1, 2'b00, 1'b1);
        #1;
        check("bp release ctRead0", ctRead0, 1'b1);
        step();
        check("bp release src0", dnSrc0, 3'd0);

        // Hits and broadcast latency
        setInputs(1'b0, 2'b00, 1'b1);
        ctHits = 5'b00001;
        upHits = {5'b00000, 5'b10000};
        dnBCST = 12'hABC;
        step();
        check("hits merge", dnHits0, 5'b10001);
        check("bcst1 dut1", ctBCST1, 12'hABC);
        check("bcst1 dut0", ctBCST0, 12'h000);
        ctHits = '0; upHits = '0;
        step();
        check("bcst2 dut0", ctBCST0, 12'h000);
        step();
        check("bcst3 ct", ctBCST0, 12'hABC);
        check("bcst3 up", upBCST0, 12'hABC);

        // Counter saturation and clear priority
        doReset();
        for (int i = 0; i < 20; i++) begin
            setInputs(1'b1, 2'b00, 1'b1);
            step();
        end
        check("sat count0", wordCount0, 4'd15);
        check("count1", wordCount1, 16'd20);
        setInputs(1'b1, 2'b00, 1'b1);
        clrCount = 1'b1;
        step();
        clrCount = 1'b0;
        check("clr count0", wordCount0, 4'd0);
        check("clr count1", wordCount1, 16'd0);
        setInputs(1'b1, 2'b00, 1'b1);
        step();

        // Reset in the middle of a stream
        setInputs(1'b1, 2'b11, 1'b1);
        ctHits = 5'b00011;
        step();
        #2;
        reset = 1'b0;
        #1;
        check("midrst dnValid", {dnValid1, dnValid0}, 2'b00);
        check("midrst dnHits", {dnHits1, dnHits0}, '0);
        check("midrst count", {wordCount1, wordCount0}, '0);
        check("midrst reads", {upRead1, ctRead1, upRead0, ctRead0}, 6'b0);
        repeat (2) begin
            @(negedge clk);
            check("midrst reads hold", {upRead1, ctRead1, upRead0, ctRead0}, 6'b0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        modelClear();
        ctHits = '0;

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            setInputs(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 3) != 0));
            clrCount = ($urandom_range(0, 15) == 0);
            ctHits   = HW'($urandom_range(0, 31));
            upHits   = (NUP*HW)'($urandom_range(0, 1023));
            dnBCST   = BW'($urandom_range(0, 4095));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
